// File: rtl/instruction_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode_pkg
// Description : Opcode constants, ALU-op encodings and control bundle for ID.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_decode_pkg;

    localparam int c_REG_IDX_W = 5;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;
    localparam logic [1:0] c_ALU_LOGIC = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode_if
// Description : Fetch/hazard/writeback inputs and decode outputs of the ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decode_if;

    logic [31:0] InstQ;
    logic [31:0] prox_dir;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        stall_pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] id_pc4;
    logic [31:0] branch_target;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic [1:0]  alu_op;
    logic        illegal;

    modport master (
        output InstQ, prox_dir, flush, ex_mem_read, ex_rt, wb_we, wb_rd, wb_data,
        input  stall_pc, rs_data, rt_data, imm_ext, rs, rt, rd, id_pc4, branch_target,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch,
               alu_op, illegal
    );

    modport slave (
        input  InstQ, prox_dir, flush, ex_mem_read, ex_rt, wb_we, wb_rd, wb_data,
        output stall_pc, rs_data, rt_data, imm_ext, rs, rt, rd, id_pc4, branch_target,
               reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch,
               alu_op, illegal
    );

endinterface
`default_nettype wire

// File: rtl/instruction_decode_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 2R/1W register file, $0 hard-wired to zero, write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import instruction_decode_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [c_REG_IDX_W-1:0] i_rs_addr,
    input  wire logic [c_REG_IDX_W-1:0] i_rt_addr,
    input  wire logic                   i_we,
    input  wire logic [c_REG_IDX_W-1:0] i_wr_addr,
    input  wire logic [31:0]            i_wr_data,
    output logic      [31:0]            o_rs_data,
    output logic      [31:0]            o_rt_data
);

    logic [31:0] r_mem [NREGS];
    logic        w_wr_live;

    assign w_wr_live = i_we && (i_wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A write landing this cycle is visible on the read ports immediately.
    always_comb begin
        o_rs_data = r_mem[i_rs_addr];
        if (i_rs_addr == '0) begin
            o_rs_data = '0;
        end else if (w_wr_live && (i_wr_addr == i_rs_addr)) begin
            o_rs_data = i_wr_data;
        end
    end

    always_comb begin
        o_rt_data = r_mem[i_rt_addr];
        if (i_rt_addr == '0) begin
            o_rt_data = '0;
        end else if (w_wr_live && (i_wr_addr == i_rt_addr)) begin
            o_rt_data = i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : IF/ID pipeline register, load-use hazard detection and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    instruction_decode_if.slave   bus
);

    logic [31:0]            r_instr;
    logic [31:0]            r_pc4;

    logic [5:0]             w_opcode;
    logic [c_REG_IDX_W-1:0] w_rs;
    logic [c_REG_IDX_W-1:0] w_rt;
    logic [c_REG_IDX_W-1:0] w_rd;
    logic [15:0]            w_imm;
    logic [31:0]            w_imm_ext;
    logic                   w_stall;
    logic                   w_illegal;
    ctrl_t                  w_ctrl;
    logic                   w_unused_bits;

    assign w_opcode      = r_instr[31:26];
    assign w_rs          = r_instr[25:21];
    assign w_rt          = r_instr[20:16];
    assign w_rd          = r_instr[15:11];
    assign w_imm         = r_instr[15:0];
    assign w_unused_bits = ^r_instr[10:0];

    assign w_stall = bus.ex_mem_read && (bus.ex_rt != '0) &&
                     ((bus.ex_rt == w_rs) || (bus.ex_rt == w_rt));

    // Flush inserts a bubble even when a stall would otherwise hold IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= '0;
            r_pc4   <= '0;
        end else if (bus.flush) begin
            r_instr <= '0;
            r_pc4   <= '0;
        end else if (!w_stall) begin
            r_instr <= bus.InstQ;
            r_pc4   <= bus.prox_dir;
        end
    end

    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.alu_op    = c_ALU_FUNCT;
            end
            c_OP_LW: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = c_ALU_ADD;
            end
            c_OP_SW: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = c_ALU_ADD;
            end
            c_OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = c_ALU_SUB;
            end
            c_OP_ADDI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = c_ALU_ADD;
            end
            c_OP_ANDI, c_OP_ORI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = c_ALU_LOGIC;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // A stalled instruction must not produce side effects downstream.
        if (w_stall) begin
            w_ctrl    = '0;
            w_illegal = 1'b0;
        end
    end

    assign w_imm_ext = extend_imm(w_imm, (w_opcode == c_OP_ANDI) || (w_opcode == c_OP_ORI));

    reg_file #(
        .NREGS (NREGS)
    ) u_reg_file (
        .clk       (clk),
        .rst       (reset),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .i_we      (bus.wb_we),
        .i_wr_addr (bus.wb_rd),
        .i_wr_data (bus.wb_data),
        .o_rs_data (bus.rs_data),
        .o_rt_data (bus.rt_data)
    );

    assign bus.stall_pc      = w_stall;
    assign bus.imm_ext       = w_imm_ext;
    assign bus.rs            = w_rs;
    assign bus.rt            = w_rt;
    assign bus.rd            = w_rd;
    assign bus.id_pc4        = r_pc4;
    assign bus.branch_target = r_pc4 + {w_imm_ext[29:0], 2'b00};
    assign bus.reg_write     = w_ctrl.reg_write;
    assign bus.mem_read      = w_ctrl.mem_read;
    assign bus.mem_write     = w_ctrl.mem_write;
    assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.alu_src       = w_ctrl.alu_src;
    assign bus.reg_dst       = w_ctrl.reg_dst;
    assign bus.branch        = w_ctrl.branch;
    assign bus.alu_op        = w_ctrl.alu_op;
    assign bus.illegal       = w_illegal;

endmodule
`default_nettype wire
